// File: rtl/inv_shift_mix.sv
// InvShiftRows followed by an optional InvMixColumns on a 128-bit AES state.
// Two-stage valid/ready pipeline with one state per cycle at full throughput.
module inv_shift_mix (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_skip_mix,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul_9(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] mul_b(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] mul_d(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] mul_e(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [127:0] s1_data_reg;
   logic         s1_skip_reg;
   logic         s1_valid_reg;
   logic [127:0] s2_data_reg;
   logic [127:0] s2_data_next;
   logic         s2_valid_reg;
   logic         s1_adv;
   logic         s2_adv;

   genvar gi;

   // Output byte (r,c) takes input byte (r,(c-r) mod 4); pure wiring.
   generate
      for (gi = 0; gi < 16; gi++) begin : g_shift
         localparam int R   = gi % 4;
         localparam int C   = gi / 4;
         localparam int SRC = R + 4 * ((C - R + 4) % 4);
         assign shifted[127-8*gi -: 8] = in_data[127-8*SRC -: 8];
      end
   endgenerate

   generate
      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = s1_data_reg[127-32*gi -: 8];
         assign a1 = s1_data_reg[119-32*gi -: 8];
         assign a2 = s1_data_reg[111-32*gi -: 8];
         assign a3 = s1_data_reg[103-32*gi -: 8];
         assign mixed[127-32*gi -: 32] = {
            mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
            mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
            mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
            mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
      end
   endgenerate

   assign s2_data_next = s1_skip_reg ? s1_data_reg : mixed;

   assign s2_adv   = !s2_valid_reg || out_ready;
   assign s1_adv   = !s1_valid_reg || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data_reg  <= '0;
         s1_skip_reg  <= 1'b0;
         s1_valid_reg <= 1'b0;
      end else if (s1_adv) begin
         s1_data_reg  <= shifted;
         s1_skip_reg  <= in_skip_mix;
         s1_valid_reg <= in_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_data_reg  <= '0;
         s2_valid_reg <= 1'b0;
      end else if (s2_adv) begin
         s2_data_reg  <= s2_data_next;
         s2_valid_reg <= s1_valid_reg;
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_data  = s2_data_reg;
   assign busy      = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_inv_shift_mix.sv
// Bench for inv_shift_mix: known-answer table, random streams with a
// scoreboard, backpressure, full-pipe pop+push and mid-stream reset.
module tb_inv_shift_mix;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_skip_mix;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   inv_shift_mix dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_skip_mix (in_skip_mix),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic         skip;
      logic [127:0] expect_data;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;
   logic [127:0] sb_q[$];
   logic [127:0] exp_in;
   logic         held_v;
   logic [127:0] held_d;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic skip);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++)
            t[rr+4*cc] = s[rr + 4*((cc - rr + 4) % 4)];
      if (!skip) begin
         for (int cc = 0; cc < 4; cc++) begin
            a0 = t[4*cc]; a1 = t[4*cc+1]; a2 = t[4*cc+2]; a3 = t[4*cc+3];
            t[4*cc]   = gmul(8'h0e,a0) ^ gmul(8'h0b,a1) ^ gmul(8'h0d,a2) ^ gmul(8'h09,a3);
            t[4*cc+1] = gmul(8'h09,a0) ^ gmul(8'h0e,a1) ^ gmul(8'h0b,a2) ^ gmul(8'h0d,a3);
            t[4*cc+2] = gmul(8'h0d,a0) ^ gmul(8'h09,a1) ^ gmul(8'h0e,a2) ^ gmul(8'h0b,a3);
            t[4*cc+3] = gmul(8'h0b,a0) ^ gmul(8'h0d,a1) ^ gmul(8'h09,a2) ^ gmul(8'h0e,a3);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] d, input logic skip);
      in_valid    = v;
      in_data     = d;
      in_skip_mix = skip;
      exp_in      = model(d, skip);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One cycle: evaluate handshakes on settled signals, then cross the edge.
   task automatic step();
      #1;
      chk("busy_vs_inflight", {127'd0, busy}, {127'd0, (sb_q.size() != 0)});
      chk("buffer_limit", {127'd0, (sb_q.size() <= 2)}, 128'd1);
      if (!in_ready)
         chk("in_ready_low_only_full", {127'd0, (sb_q.size() == 2 && !out_ready)}, 128'd1);
      if (held_v) begin
         chk("stall_valid_hold", {127'd0, out_valid}, 128'd1);
         chk("stall_data_hold", out_data, held_d);
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_output: got %h, required no output", out_data);
         end else begin
            chk("scoreboard_data", out_data, sb_q.pop_front());
            pops++;
         end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_in);
      $display("step t=%0t in_v=%0b in_r=%0b out_v=%0b out_r=%0b out=%h inflight=%0d",
               $time, in_valid, in_ready, out_valid, out_ready, out_data, sb_q.size());
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int budget = 0;
      drive(1'b0, '0, 1'b0);
      out_ready = 1'b1;
      while (sb_q.size() != 0 && budget < 10) begin
         step();
         budget++;
      end
      chk("drain_empty", {96'd0, sb_q.size()}, 128'd0);
   endtask

   vec_t tbl[5];

   initial begin
      tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h000d0a0704010e0b0805020f0c090603};
      tbl[1] = '{{4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}}};
      tbl[2] = '{{4{32'h9fdc589d}}, 1'b0, {4{32'hf20a225c}}};
      tbl[3] = '{{4{32'h01010101}}, 1'b0, {4{32'h01010101}}};
      tbl[4] = '{{4{32'h8e4da1bc}}, 1'b1, {4{32'h8e4da1bc}}};

      rst_n     = 1'b0;
      out_ready = 1'b0;
      held_v    = 1'b0;
      held_d    = '0;
      drive(1'b0, '0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_out_data", out_data, 128'd0);
      chk("reset_busy", {127'd0, busy}, 128'd0);
      chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Known answers with latency check
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, tbl[i].data, tbl[i].skip);
         exp_in = tbl[i].expect_data;
         #1;
         chk("kat_in_ready", {127'd0, in_ready}, 128'd1);
         step();
         drive(1'b0, '0, 1'b0);
         #1;
         chk("kat_latency_not_early", {127'd0, out_valid}, 128'd0);
         step();
         #1;
         chk("kat_latency_valid", {127'd0, out_valid}, 128'd1);
         step();
      end
      chk("kat_all_out", {96'd0, sb_q.size()}, 128'd0);

      // Throughput
      pops = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, rand128(), 1'($urandom_range(0, 1)));
         #1;
         chk("thru_in_ready", {127'd0, in_ready}, 128'd1);
         if (i >= 2) chk("thru_out_valid", {127'd0, out_valid}, 128'd1);
         step();
      end
      drain();
      chk("thru_count", {96'd0, pops}, 128'd16);

      // Backpressure with a forced 5-cycle stall
      for (int i = 0; i < 60; i++) begin
         drive(($urandom_range(0, 3) != 0), rand128(), 1'($urandom_range(0, 1)));
         out_ready = (i >= 10 && i < 15) ? 1'b0 : 1'($urandom_range(0, 1));
         step();
      end
      drain();

      // Full-pipe pop+push
      out_ready = 1'b0;
      drive(1'b1, rand128(), 1'b0);
      step();
      drive(1'b1, rand128(), 1'b1);
      step();
      drive(1'b1, rand128(), 1'b0);
      #1;
      chk("full_in_ready_low", {127'd0, in_ready}, 128'd0);
      step();
      out_ready = 1'b1;
      #1;
      chk("poppush_in_ready", {127'd0, in_ready}, 128'd1);
      chk("poppush_out_valid", {127'd0, out_valid}, 128'd1);
      step();
      drive(1'b0, '0, 1'b0);
      #1;
      chk("poppush_busy", {127'd0, busy}, 128'd1);
      chk("poppush_inflight", {96'd0, sb_q.size()}, 128'd2);
      drain();

      // Mid-stream reset with both stages full
      out_ready = 1'b0;
      drive(1'b1, rand128(), 1'b0);
      step();
      drive(1'b1, rand128(), 1'b0);
      step();
      #1;
      chk("prereset_full", {127'd0, (out_valid && busy && !in_ready)}, 128'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", {127'd0, out_valid}, 128'd0);
      chk("midreset_busy", {127'd0, busy}, 128'd0);
      chk("midreset_in_ready", {127'd0, in_ready}, 128'd1);
      sb_q.delete();
      held_v = 1'b0;
      drive(1'b0, '0, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("postreset_no_stale", {127'd0, out_valid}, 128'd0);
         step();
      end
      drive(1'b1, tbl[0].data, tbl[0].skip);
      exp_in = tbl[0].expect_data;
      step();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inv_shift_mix.md
# inv_shift_mix

Decryption-side counterpart of the encryption ShiftRows stage. The block applies InvShiftRows followed by InvMixColumns to a 128-bit AES state, as used by the FIPS-197 equivalent inverse cipher round (InvSubBytes → InvShiftRows → InvMixColumns → AddRoundKey with a transformed key). It is a 2-stage, fully pipelined unit with valid/ready handshakes on both sides, one state per cycle at full throughput. A per-state skip flag bypasses InvMixColumns for the final round.

## Interface

Parameters: none. Polynomial 0x11B, byte layout and latency are fixed.

- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/in_skip_mix are valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  128  AES state
- in_skip_mix  in  1  1 = final round; InvShiftRows only
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts output this cycle
- out_data  out  128  transformed state
- busy  out  1  any pipeline stage holds a state

## Operation

- Byte layout: byte i = data[127-8i -: 8], row r = i mod 4, column c = i div 4. Byte 0 is at [127:120]; columns are contiguous 32-bit words.
- InvShiftRows: out(r,c) = in(r,(c−r) mod 4). Row 0 is unchanged; rows 1/2/3 rotate right by 1/2/3.
- InvMixColumns, per column (a0..a3 = rows 0..3), all arithmetic in GF(2^8) mod 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Multiplies are built from xtime (shift left 1; XOR 0x1B if the bit 7 shifted out was 1). No lookup tables.
- Stage 1 register: InvShiftRows(in_data), the skip flag, s1_valid.
- Stage 2 register: skip ? s1_data : InvMixColumns(s1_data), plus s2_valid. Stage 2 drives out_data/out_valid directly.
- Pipeline control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational; no combinational path from in_valid)
  - Stage 1 loads when s1_adv; s1_valid ← in_valid.
  - Stage 2 loads when s2_adv; s2_valid ← s1_valid.
  - A register with valid=0 may load arbitrary data. Data registers load only on advance.
- busy = s1_valid | s2_valid.

## Timing

- Reset (rst_n low, asynchronous): s1_valid = s2_valid = 0, s1/s2 data = 0, skip = 0. Resulting outputs: out_valid 0, out_data 0, busy 0, in_ready 1. Takes effect immediately, mid-transfer included. States in flight are discarded, not flushed. First acceptance is possible on the first rising edge with rst_n high.
- Latency: a state accepted on edge E (in_valid & in_ready) appears with out_valid = 1 right after edge E+1, provided out_ready was high (or s2 was empty) at E+1.
- Throughput: 1 state/cycle while out_ready = 1. Back-to-back inputs emerge back-to-back, in order. No drops, no duplicates.
- Backpressure: while out_valid & !out_ready, out_data and out_valid hold stable. Stage 1 still fills if empty, so 2 states can be buffered. in_ready drops only when both stages are full and out_ready = 0.
- Simultaneous pop and push when both stages are full: with out_ready = 1, both stages advance and in_ready = 1 in the same cycle.
- The skip flag travels with its state. Mixed skip/non-skip sequences are processed per state.

## Test plan

- Reset: assert rst_n low mid-stream with both stages full. Required: out_valid 0, busy 0, in_ready 1 immediately, before the next edge. After release, no stale state is emitted.
- InvShiftRows only: in_data 0x000102030405060708090a0b0c0d0e0f with skip = 1. Required: out_data 0x000d0a0704010e0b0805020f0c090603, 2 edges after acceptance.
- InvMixColumns: in_data = column 0x8e4da1bc repeated ×4, skip = 0 (InvShiftRows is the identity here). Required: 0xdb135345 ×4. Repeat with 0x9fdc589d ×4 → 0xf20a225c ×4; 0x01010101 ×4 → unchanged.
- Throughput: 16 back-to-back random states with out_ready tied high and skip randomized. Required: in_ready constantly 1, outputs in order, every state matches the reference model, one output per cycle.
- Backpressure: stream while out_ready toggles randomly (including 5 consecutive low cycles). Required: at most 2 states buffered, in_ready low only when full, out_data stable while stalled, no loss or reordering.
- Full-pipe pop+push: both stages full, then out_ready = 1 and in_valid = 1 in the same cycle. Required: one output consumed and one input accepted on that edge; busy stays 1.
